// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: Q1..Q4 execute sequencer for the PIC16C5x ALU datapath.
// Optional conditional skips (DECFSZ/INCFSZ/BTFSC/BTFSS): ALU_CTRL_SKIP_EN.
`ifndef ALU_FUNC_WIDTH
`define ALU_FUNC_WIDTH 5
`define ALU_IDLE  5'd0
`define ALU_ADDWF 5'd1
`define ALU_SUBWF 5'd2
`define ALU_ANDWF 5'd3
`define ALU_IORWF 5'd4
`define ALU_XORWF 5'd5
`define ALU_COMF  5'd6
`define ALU_DECF  5'd7
`define ALU_INCF  5'd8
`define ALU_MOVF  5'd9
`define ALU_RLF   5'd10
`define ALU_RRF   5'd11
`define ALU_SWAPF 5'd12
`define ALU_BCF   5'd13
`define ALU_BSF   5'd14
`define ALU_ANDLW 5'd15
`define ALU_IORLW 5'd16
`define ALU_XORLW 5'd17
`endif

module alu_exec_ctrl #(
  parameter int INST_WIDTH  = 12,
  parameter int FADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INST_WIDTH-1:0]      instIn,
  input  logic                       instValid,
  output logic                       instReady,
  input  logic [7:0]                 fDataIn,
  input  logic [7:0]                 aluResultIn,
  output logic [`ALU_FUNC_WIDTH-1:0] aluFuncOut,
  output logic [2:0]                 bitSelOut,
  output logic [7:0]                 litOut,
  output logic [FADDR_WIDTH-1:0]     fAddrOut,
  output logic                       fReadEn,
  output logic                       fWriteEn,
  output logic                       wWriteEn,
  output logic                       wSrcLit,
  output logic                       ALU_En,
  output logic                       skipOut,
  output logic [1:0]                 phaseOut,
  output logic                       busyOut
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_Q1,
    S_Q2,
    S_Q3,
    S_Q4
  } state_t;

  state_t                  state_q, state_d;
  logic [INST_WIDTH-1:0]   inst_q, inst_d;
  logic                    accept;
  logic                    live;

  logic [`ALU_FUNC_WIDTH-1:0] func_c;
  logic rd_c;
  logic use_d;
  logic wf_fix;
  logic ww_fix;
  logic aen_c;
  logic lit0_c;
  logic wlit_c;
  logic skz_c;
  logic btc_c;
  logic bts_c;
  logic wr_f;
  logic wr_w;

  // Phase sequencer: next state, handshake and phase/busy outputs
  always_comb begin
    state_d   = state_q;
    instReady = 1'b0;
    busyOut   = 1'b0;
    phaseOut  = 2'd0;
    unique case (state_q)
      S_IDLE: begin
        instReady = 1'b1;
        if (instValid) state_d = S_Q1;
      end
      S_Q1: begin
        busyOut  = 1'b1;
        phaseOut = 2'd0;
        state_d  = S_Q2;
      end
      S_Q2: begin
        busyOut  = 1'b1;
        phaseOut = 2'd1;
        state_d  = S_Q3;
      end
      S_Q3: begin
        busyOut  = 1'b1;
        phaseOut = 2'd2;
        state_d  = S_Q4;
      end
      S_Q4: begin
        busyOut   = 1'b1;
        phaseOut  = 2'd3;
        instReady = 1'b1;
        state_d   = instValid ? S_Q1 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = instReady & instValid;

  // Instruction register loads only on an accepted handshake
  always_comb begin
    inst_d = inst_q;
    if (accept) inst_d = instIn;
  end

  // Decode the held instruction word into function and strobe classes
  always_comb begin
    func_c = `ALU_IDLE;
    rd_c   = 1'b0;
    use_d  = 1'b0;
    wf_fix = 1'b0;
    ww_fix = 1'b0;
    aen_c  = 1'b0;
    lit0_c = 1'b0;
    wlit_c = 1'b0;
    skz_c  = 1'b0;
    btc_c  = 1'b0;
    bts_c  = 1'b0;
    unique casez (inst_q[11:0])
      12'b0000_001?_????: begin
        func_c = `ALU_IORLW;
        lit0_c = 1'b1;
        wf_fix = 1'b1;
      end
      12'b0000_010?_????: begin
        func_c = `ALU_ANDLW;
        lit0_c = 1'b1;
        ww_fix = 1'b1;
        aen_c  = 1'b1;
      end
      12'b0000_011?_????: begin
        func_c = `ALU_ANDLW;
        lit0_c = 1'b1;
        wf_fix = 1'b1;
        aen_c  = 1'b1;
      end
      12'b0000_10??_????: begin
        func_c = `ALU_SUBWF;
        rd_c = 1'b1; use_d = 1'b1; aen_c = 1'b1;
      end
      12'b0000_11??_????: begin
        func_c = `ALU_DECF;
        rd_c = 1'b1; use_d = 1'b1; aen_c = 1'b1;
      end
      12'b0001_00??_????: begin
        func_c = `ALU_IORWF;
        rd_c = 1'b1; use_d = 1'b1; aen_c = 1'b1;
      end
      12'b0001_01??_????: begin
        func_c = `ALU_ANDWF;
        rd_c = 1'b1; use_d = 1'b1; aen_c = 1'b1;
      end
      12'b0001_10??_????: begin
        func_c = `ALU_XORWF;
        rd_c = 1'b1; use_d = 1'b1; aen_c = 1'b1;
      end
      12'b0001_11??_????: begin
        func_c = `ALU_ADDWF;
        rd_c = 1'b1; use_d = 1'b1; aen_c = 1'b1;
      end
      12'b0010_00??_????: begin
        func_c = `ALU_MOVF;
        rd_c = 1'b1; use_d = 1'b1; aen_c = 1'b1;
      end
      12'b0010_01??_????: begin
        func_c = `ALU_COMF;
        rd_c = 1'b1; use_d = 1'b1; aen_c = 1'b1;
      end
      12'b0010_10??_????: begin
        func_c = `ALU_INCF;
        rd_c = 1'b1; use_d = 1'b1; aen_c = 1'b1;
      end
      12'b0011_00??_????: begin
        func_c = `ALU_RRF;
        rd_c = 1'b1; use_d = 1'b1; aen_c = 1'b1;
      end
      12'b0011_01??_????: begin
        func_c = `ALU_RLF;
        rd_c = 1'b1; use_d = 1'b1; aen_c = 1'b1;
      end
      12'b0011_10??_????: begin
        func_c = `ALU_SWAPF;
        rd_c = 1'b1; use_d = 1'b1;
      end
      12'b0100_????_????: begin
        func_c = `ALU_BCF;
        rd_c = 1'b1; wf_fix = 1'b1;
      end
      12'b0101_????_????: begin
        func_c = `ALU_BSF;
        rd_c = 1'b1; wf_fix = 1'b1;
      end
      12'b1100_????_????: begin
        ww_fix = 1'b1;
        wlit_c = 1'b1;
      end
      12'b1101_????_????: begin
        func_c = `ALU_IORLW;
        ww_fix = 1'b1; aen_c = 1'b1;
      end
      12'b1110_????_????: begin
        func_c = `ALU_ANDLW;
        ww_fix = 1'b1; aen_c = 1'b1;
      end
      12'b1111_????_????: begin
        func_c = `ALU_XORLW;
        ww_fix = 1'b1; aen_c = 1'b1;
      end
`ifdef ALU_CTRL_SKIP_EN
      12'b0010_11??_????: begin
        func_c = `ALU_DECF;
        rd_c = 1'b1; use_d = 1'b1; skz_c = 1'b1;
      end
      12'b0011_11??_????: begin
        func_c = `ALU_INCF;
        rd_c = 1'b1; use_d = 1'b1; skz_c = 1'b1;
      end
      12'b0110_????_????: begin
        rd_c = 1'b1; btc_c = 1'b1;
      end
      12'b0111_????_????: begin
        rd_c = 1'b1; bts_c = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign wr_f = wf_fix | (use_d & inst_q[5]);
  assign wr_w = ww_fix | (use_d & ~inst_q[5]);

  assign aluFuncOut = func_c;
  assign bitSelOut  = inst_q[7:5];
  assign litOut     = lit0_c ? 8'h00 : inst_q[7:0];
  assign fAddrOut   = inst_q[FADDR_WIDTH-1:0];

`ifdef ALU_CTRL_SKIP_EN
  logic pend_q, pend_d;
  logic annul_q, annul_d;
  logic skip_hit;
  logic skip_now;
  logic sel_bit;

  assign live = ~annul_q;

  // Skip resolution in Q4 and hand-off of the annul flag to the next word
  always_comb begin
    sel_bit  = fDataIn[inst_q[7:5]];
    skip_hit = (skz_c & (aluResultIn == 8'h00)) |
               (btc_c & ~sel_bit) |
               (bts_c & sel_bit);
    skip_now = (state_q == S_Q4) & live & skip_hit;
    pend_d   = pend_q;
    annul_d  = annul_q;
    if (accept) begin
      annul_d = pend_q | skip_now;
      pend_d  = 1'b0;
    end else if (skip_now) begin
      pend_d = 1'b1;
    end
  end

  assign skipOut = skip_now;

  // Skip bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= 1'b0;
      annul_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      annul_q <= annul_d;
    end
  end
`else
  logic unused_skip_inputs;

  assign live    = 1'b1;
  assign skipOut = 1'b0;
  assign unused_skip_inputs = ^{aluResultIn, fDataIn,
                                skz_c, btc_c, bts_c};
`endif

  // Phase-gated strobes; an annulled word drives none of them
  always_comb begin
    fReadEn  = live & (state_q == S_Q2) & rd_c;
    fWriteEn = live & (state_q == S_Q4) & wr_f;
    wWriteEn = live & (state_q == S_Q4) & wr_w;
    wSrcLit  = live & (state_q == S_Q4) & wlit_c;
    ALU_En   = live & (state_q == S_Q4) & aen_c;
  end

  // State and instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
    end
  end

endmodule
